// File: rtl/adder_tree_acc.sv
// Pipelined signed/unsigned reduction tree over NUM lanes with a multi-beat group
// accumulator. One register stage per tree level, plus one accumulator stage.

module adder_tree_acc_node #(
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W:0]   o_sum
);
  logic [W:0] w_a, w_b;

  assign w_a = (SIGNED != 0) ? {i_a[W-1], i_a} : {1'b0, i_a};
  assign w_b = (SIGNED != 0) ? {i_b[W-1], i_b} : {1'b0, i_b};

  // Tree data is deliberately not reset; the valid tags qualify it.
  always_ff @(posedge clk)
    o_sum <= w_a + w_b;
endmodule

module adder_tree_acc #(
  parameter int SIZE   = 8,
  parameter int NUM    = 8,
  parameter int SIGNED = 0,
  parameter int ACC_W  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              in_last,
  input  logic [NUM*SIZE-1:0]               din,
  output logic                              out_valid,
  output logic [SIZE+$clog2(NUM)+ACC_W-1:0] dout,
  output logic [ACC_W:0]                    out_beats,
  output logic                              out_ovf
);
  localparam int L  = $clog2(NUM);
  localparam int TW = SIZE + L;
  localparam int OW = TW + ACC_W;
  localparam logic [ACC_W:0] BMAX = {1'b1, {ACC_W{1'b0}}};

  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int NI = (NUM + (1 << j) - 1) >> j;
    localparam int NO = (NI + 1) / 2;
    localparam int WI = SIZE + j;

    logic [NI-1:0][WI-1:0] w_in;
    logic [NO-1:0][WI:0]   r_sum;

    if (j == 0) begin : g_src
      assign w_in = din;
    end else begin : g_chain
      assign w_in = g_lvl[j-1].r_sum;
    end

    for (genvar k = 0; k < NO; k++) begin : g_node
      logic [WI-1:0] w_b;
      // An odd tail element pairs with zero, i.e. passes through extended.
      if (2*k+1 < NI) begin : g_pair
        assign w_b = w_in[2*k+1];
      end else begin : g_tail
        assign w_b = '0;
      end
      adder_tree_acc_node #(.W(WI), .SIGNED(SIGNED)) u_node (
        .clk  (clk),
        .i_a  (w_in[2*k]),
        .i_b  (w_b),
        .o_sum(r_sum[k])
      );
    end
  end

  logic [TW-1:0] w_tree;
  logic [OW-1:0] w_tree_ext;
  assign w_tree     = g_lvl[L-1].r_sum;
  assign w_tree_ext = (SIGNED != 0) ? {{ACC_W{w_tree[TW-1]}}, w_tree}
                                    : {{ACC_W{1'b0}}, w_tree};

  // Tags: bit 0 is the live input, bit L lines up with the tree output.
  logic [L-1:0] r_vld_sr, r_lst_sr;
  logic [L:0]   w_vld_pipe, w_lst_pipe;
  assign w_vld_pipe = {r_vld_sr, in_valid};
  assign w_lst_pipe = {r_lst_sr, in_valid & in_last};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_sr <= '0;
      r_lst_sr <= '0;
    end else begin
      r_vld_sr <= w_vld_pipe[L-1:0];
      r_lst_sr <= w_lst_pipe[L-1:0];
    end
  end

  logic [OW-1:0]  r_acc, r_dout, w_sum;
  logic [ACC_W:0] r_beats, r_out_beats, w_beats;
  logic           r_acc_open, r_ovf, r_out_ovf, r_out_valid, w_ovf;

  always_comb begin
    w_sum   = w_tree_ext;
    w_beats = (ACC_W+1)'(1);
    w_ovf   = 1'b0;
    if (r_acc_open) begin
      w_sum   = r_acc + w_tree_ext;
      w_beats = (r_beats == BMAX) ? BMAX : r_beats + (ACC_W+1)'(1);
      w_ovf   = r_ovf | (r_beats == BMAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_beats     <= '0;
      r_acc_open  <= 1'b0;
      r_ovf       <= 1'b0;
      r_dout      <= '0;
      r_out_beats <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_vld_pipe[L]) begin
        if (w_lst_pipe[L]) begin
          r_dout      <= w_sum;
          r_out_beats <= w_beats;
          r_out_ovf   <= w_ovf;
          r_out_valid <= 1'b1;
          r_acc_open  <= 1'b0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc      <= w_sum;
          r_beats    <= w_beats;
          r_ovf      <= w_ovf;
          r_acc_open <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign out_beats = r_out_beats;
  assign out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: three configurations driven in lockstep and checked
// against a group-sum reference model with an expected-result queue.

module tb_adder_tree_acc;
  logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [63:0] din0 = '0;
  logic [19:0] din2 = '0;
  logic        v0, v1, v2, f0, f1, f2;
  logic [14:0] d0, d1;
  logic [10:0] d2;
  logic [4:0]  b0, b1, b2;

  always #5 clk = ~clk;

  adder_tree_acc #(.SIZE(8), .NUM(8), .SIGNED(0), .ACC_W(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .din(din0),
    .out_valid(v0), .dout(d0), .out_beats(b0), .out_ovf(f0));
  adder_tree_acc #(.SIZE(8), .NUM(8), .SIGNED(1), .ACC_W(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .din(din0),
    .out_valid(v1), .dout(d1), .out_beats(b1), .out_ovf(f1));
  adder_tree_acc #(.SIZE(4), .NUM(5), .SIGNED(0), .ACC_W(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .din(din2),
    .out_valid(v2), .dout(d2), .out_beats(b2), .out_ovf(f2));

  typedef struct {int due; longint s0; longint s1; longint s2; int nb;} exp_t;
  exp_t   q[$];
  int     ln[8];
  int     ecnt = 0, nassert = 0, nfail = 0, gn = 0, hb = 0;
  longint g0 = 0, g1 = 0, g2 = 0, h0 = 0, h1 = 0, h2 = 0;
  bit     ho = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  task automatic fill(int a);
    for (int k = 0; k < 8; k++) ln[k] = a;
  endtask

  // Reference: a beat contributes the plain sum of its lanes; a group reports
  // L+1 = 4 edges after its closing beat, beats saturate at 16, overflow past 16.
  task automatic absorb(bit l);
    byte sb;
    for (int k = 0; k < 8; k++) begin
      sb = ln[k][7:0];
      g0 += ln[k] & 255;
      g1 += sb;
    end
    for (int k = 0; k < 5; k++) g2 += ln[k] & 15;
    gn++;
    if (l) begin
      q.push_back('{ecnt + 3, g0, g1, g2, gn});
      g0 = 0; g1 = 0; g2 = 0; gn = 0;
    end
  endtask

  task automatic check();
    exp_t e;
    bit   ev;
    ev = 1'b0;
    if (q.size() > 0) ev = (q[0].due == ecnt);
    chk("valid0", v0, ev);
    chk("valid1", v1, ev);
    chk("valid2", v2, ev);
    if (ev) begin
      e  = q.pop_front();
      h0 = e.s0 & 'h7FFF;
      h1 = e.s1 & 'h7FFF;
      h2 = e.s2 & 'h7FF;
      hb = (e.nb > 16) ? 16 : e.nb;
      ho = (e.nb > 16);
    end
    chk("dout0", d0, h0);
    chk("dout1", d1, h1);
    chk("dout2", d2, h2);
    chk("beats0", b0, hb);
    chk("beats2", b2, hb);
    chk("ovf0", f0, ho);
    chk("ovf1", f1, ho);
  endtask

  task automatic drive(bit v, bit l);
    in_valid = v;
    in_last  = l;
    for (int k = 0; k < 8; k++) din0[k*8 +: 8] = ln[k][7:0];
    for (int k = 0; k < 5; k++) din2[k*4 +: 4] = ln[k][3:0];
    @(posedge clk);
    ecnt++;
    if (!rst && v) absorb(l);
    @(negedge clk);
    check();
  endtask

  // Reset discards the open group and everything still in flight.
  task automatic do_reset(int n);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    q.delete();
    g0 = 0; g1 = 0; g2 = 0; gn = 0;
    h0 = 0; h1 = 0; h2 = 0; hb = 0; ho = 0;
    #1;
    check();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      ecnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    check();
  endtask

  initial begin
    fill(0);
    #2;
    do_reset(2);

    fill(255); drive(1, 1);                 // 2040 / -8 / 75
    fill(0);   repeat (5) drive(0, 0);
    fill(128); drive(1, 1);                 // signed: -1024
    for (int k = 0; k < 8; k++) ln[k] = (k % 2 == 0) ? 127 : 128;
    drive(1, 1);                            // signed: -4
    fill(0); ln[4] = 9; drive(1, 1);        // odd-lane pass-through
    fill(0); repeat (5) drive(0, 0);

    fill(1); drive(1, 0);                   // three-beat group with a gap
    fill(7); drive(0, 1);                   // in_last ignored while invalid
    fill(2); drive(1, 0);
    fill(3); drive(1, 1);
    fill(0); repeat (5) drive(0, 0);

    for (int i = 1; i <= 3; i++) begin fill(i); drive(1, 1); end
    fill(0); repeat (5) drive(0, 0);

    fill(1);
    for (int i = 1; i <= 17; i++) drive(1, i == 17);
    fill(4); drive(1, 1);                   // overflow flag clears per group
    fill(0); repeat (5) drive(0, 0);

    fill(6); drive(1, 0); drive(1, 0);
    do_reset(2);
    fill(5); drive(1, 1);
    fill(0); repeat (5) drive(0, 0);

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 8; k++) ln[k] = $urandom_range(0, 255);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end
    fill(0); drive(1, 1);
    repeat (6) drive(0, 0);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/adder_tree_acc.md
Name: adder_tree_acc

Overview:
- Next-generation pipelined reduction tree for the dot-product datapath.
- Sums NUM lanes per beat, in signed or unsigned mode, and handles any NUM >= 2, including non-powers-of-two.
- Carries valid/last tags alongside the data and accumulates per-beat sums across a multi-beat group, closed by in_last.
- Sits after the multiplier array; presents one registered result per group to the dot-product output stage.

Parameters:
- SIZE, 8, lane width in bits.
- NUM, 8, lanes per beat; legal range 2..1024.
- SIGNED, 0, 0 = unsigned lanes (zero-extend), 1 = two's-complement lanes (sign-extend).
- ACC_W, 4, extra accumulator bits; a group may hold up to 2^ACC_W beats without overflow.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  beat present on din.
- in_last  in  1  final beat of the current group; sampled only when in_valid=1.
- din  in  NUM*SIZE  packed lanes; lane k occupies bits [k*SIZE +: SIZE].
- out_valid  out  1  one-cycle pulse; dout, out_beats and out_ovf are valid.
- dout  out  SIZE+$clog2(NUM)+ACC_W  group sum.
- out_beats  out  ACC_W+1  number of beats in the reported group, saturating at 2^ACC_W.
- out_ovf  out  1  group exceeded 2^ACC_W beats; dout is not trustworthy.

Behaviour:
- Tree depth L = $clog2(NUM), one register stage per level.
- Level j (input width SIZE+j) forms pairwise sums of width SIZE+j+1.
- Odd element count at a level: the last element is registered unchanged, extended by one bit per SIGNED.
- Extension rule at every level: sign-extend when SIGNED=1, zero-extend when SIGNED=0. No truncation anywhere.
- Valid and last tags travel in a shift register of depth L, aligned with the tree data.
- Only the tag register and the accumulator-stage state are reset. Tree data registers are not reset.
- Accumulator stage (stage L+1) acts on a tree-output beat whose valid tag is 1:
  - acc_open=0: sum = tree_out, beats = 1.
  - acc_open=1: sum = acc + tree_out, beats = beats+1, saturating at 2^ACC_W.
  - ovf becomes sticky 1 when a beat arrives while beats already = 2^ACC_W.
  - last=0: acc <= sum, acc_open <= 1.
  - last=1: dout <= sum, out_beats <= beats, out_ovf <= ovf, out_valid <= 1; then acc_open <= 0 and ovf <= 0.
- Accumulator and dout are the sign- or zero-extended tree output at full output width. Arithmetic wraps modulo 2^width.
- out_valid is 1 for exactly one cycle per closing beat. dout, out_beats and out_ovf hold their values until the next closing beat.
- Latency: in_valid=1 with in_last=1 at edge t gives out_valid=1 after edge t+L+1. Single-beat groups have the same latency.
- Throughput: one beat per cycle, no backpressure.
- Back-to-back groups are legal: a beat following a last=1 beat opens a new group with no bubble.
- Cycles with in_valid=0 inside a group are legal; the accumulator holds its value.
- in_last is ignored when in_valid=0.
- Reset values: out_valid=0, dout=0, out_beats=0, out_ovf=0, acc=0, acc_open=0, ovf=0, all valid/last tags=0.
- Reset asserted mid-group:
  - The partial group and all in-flight beats are discarded; no out_valid is produced for them.
  - The first valid beat after reset deasserts opens a new group.
- NUM=2: L=1, a single adder stage.

Test Plan:
- SIZE=8, NUM=8, SIGNED=0, ACC_W=4; all lanes 255, in_valid=1, in_last=1 at cycle 0 -> out_valid pulse at cycle 4, dout=2040, out_beats=1, out_ovf=0.
- SIGNED=1, same sizes; all lanes 8'h80 (-128), single beat -> dout=-1024 (15'h7C00), out_beats=1. Separately, lanes alternating +127/-128 -> dout=-4.
- Three-beat group, lanes = 1, then 2, then 3 (last on beat 3), with a one-cycle in_valid=0 gap after beat 1 -> one out_valid only, 4 cycles after beat 3; dout=48, out_beats=3.
- NUM=5, SIZE=4, SIGNED=0 (L=3), lanes {15,15,15,15,15}, single beat -> dout=75 at cycle 4. Also verify the odd-lane pass-through using lanes {0,0,0,0,9} -> dout=9.
- Back-to-back single-beat groups on consecutive cycles with lane values 1, 2, 3 -> out_valid high on 3 consecutive cycles; dout = 8, 16, 24.
- Boundary and reset:
  - 17 beats of all-1 lanes with last on beat 17 (ACC_W=4) -> out_beats=16, out_ovf=1.
  - The next single-beat group -> out_ovf=0.
  - rst pulsed between beats 2 and 3 of a 4-beat group -> no out_valid for that group; a fresh single beat after reset yields its own sum only.
